// File: rtl/pixel_diffuser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_diffuser_pkg
// Description : Shared types and constants for the pixel diffuser block:
//               channel/pixel widths, mode encoding and the control FSM
//               state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_diffuser_pkg;

  localparam int CH_W  = 8;
  localparam int PIX_W = 24;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage : pixel_diffuser_pkg
`default_nettype wire

// File: rtl/pixel_diffuser_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_diffuser_if
// Description : Bundles the key-set handshake, the input pixel stream, the
//               output pixel stream and the busy flag of the pixel diffuser.
// Ports       : master - drives mode, keys, input stream and m_ready
//               slave  - the diffuser side; drives key_ready, s_ready,
//                        output stream and busy
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_diffuser_if;
  import pixel_diffuser_pkg::*;

  logic             mode;
  logic             key_valid;
  logic             key_ready;
  logic [22:0]      key1;
  logic [22:0]      key2;
  logic [22:0]      key3;
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_last;
  logic             busy;

  modport master (
    output mode, key_valid, key1, key2, key3,
    output s_valid, s_data, s_last, m_ready,
    input  key_ready, s_ready, m_valid, m_data, m_last, busy
  );

  modport slave (
    input  mode, key_valid, key1, key2, key3,
    input  s_valid, s_data, s_last, m_ready,
    output key_ready, s_ready, m_valid, m_data, m_last, busy
  );

endinterface : pixel_diffuser_if
`default_nettype wire

// File: rtl/pixel_diffuser_diffuse_channel.sv
`default_nettype none
// ============================================================================
// Module      : pixel_diffuser_diffuse_channel
// Description : Combinational diffusion of one 8-bit colour channel.
//               Encrypt: out = ((in + k + fb) mod 256) ^ k, next fb = out
//               Decrypt: out = ((in ^ k) - k - fb) mod 256, next fb = in
//               In both directions the feedback is the ciphertext byte,
//               which is what makes decrypt the exact inverse of encrypt.
// Ports       : i_data    - input channel byte
//               i_key     - channel key byte
//               i_fb      - current feedback byte
//               i_mode    - 0 encrypt, 1 decrypt
//               o_data    - diffused channel byte
//               o_next_fb - feedback for the following pixel
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_diffuser_diffuse_channel
  import pixel_diffuser_pkg::*;
(
  input  logic [CH_W-1:0] i_data,
  input  logic [CH_W-1:0] i_key,
  input  logic [CH_W-1:0] i_fb,
  input  logic            i_mode,
  output logic [CH_W-1:0] o_data,
  output logic [CH_W-1:0] o_next_fb
);

  logic [CH_W-1:0] w_sum;
  logic [CH_W-1:0] w_enc;
  logic [CH_W-1:0] w_unmask;
  logic [CH_W-1:0] w_dec;

  // 8-bit operands keep every sum/difference wrapping mod 256.
  assign w_sum    = i_data + i_key + i_fb;
  assign w_enc    = w_sum ^ i_key;
  assign w_unmask = i_data ^ i_key;
  assign w_dec    = w_unmask - i_key - i_fb;

  assign o_data    = (i_mode == MODE_DEC) ? w_dec  : w_enc;
  assign o_next_fb = (i_mode == MODE_DEC) ? i_data : w_enc;

endmodule : pixel_diffuser_diffuse_channel
`default_nettype wire

// File: rtl/pixel_diffuser.sv
`default_nettype none
// ============================================================================
// Module      : pixel_diffuser
// Description : Applies a per-frame key set to an RGB pixel stream using
//               ciphertext-feedback diffusion per colour channel (encrypt)
//               or its inverse (decrypt). One pixel per cycle, one-cycle
//               registered latency, valid/ready on both streams.
// Ports       : clk - clock
//               rst - asynchronous active-high reset
//               bus - pixel_diffuser_if.slave: key set handshake (mode,
//                     key_valid/key_ready, key1..3), input stream
//                     (s_valid/s_ready/s_data/s_last), output stream
//                     (m_valid/m_ready/m_data/m_last) and busy
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_diffuser
  import pixel_diffuser_pkg::*;
#(
  parameter logic [PIX_W-1:0] IV = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  pixel_diffuser_if.slave   bus
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [PIX_W-1:0] r_key;      // {k_r, k_g, k_b}
  logic [PIX_W-1:0] r_fb;       // {fb_r, fb_g, fb_b}
  logic             r_mode;
  logic             r_m_valid;
  logic [PIX_W-1:0] r_m_data;
  logic             r_m_last;

  logic             w_key_ready;
  logic             w_s_ready;
  logic             w_key_hs;
  logic             w_s_hs;
  logic             w_m_hs;
  logic [PIX_W-1:0] w_out;
  logic [PIX_W-1:0] w_fb_nxt;

  // Only the low byte of each key word is used (key mod 256).
  logic             w_unused;
  assign w_unused = ^{bus.key1[22:CH_W], bus.key2[22:CH_W], bus.key3[22:CH_W]};

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_ready = 1'b0;
    w_s_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        w_key_ready = 1'b1;
        if (bus.key_valid) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // The output register can take a new pixel if it is empty or is
        // being emptied in this same cycle.
        w_s_ready = !r_m_valid || bus.m_ready;
        if (bus.s_valid && w_s_ready && bus.s_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (r_m_valid && bus.m_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_key_hs = bus.key_valid & w_key_ready;
  assign w_s_hs   = bus.s_valid & w_s_ready;
  assign w_m_hs   = r_m_valid & bus.m_ready;

  // --------------------------------------------------------------------------
  // Per-channel diffusion datapath
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    pixel_diffuser_diffuse_channel u_ch (
      .i_data    (bus.s_data[gi*CH_W +: CH_W]),
      .i_key     (r_key[gi*CH_W +: CH_W]),
      .i_fb      (r_fb[gi*CH_W +: CH_W]),
      .i_mode    (r_mode),
      .o_data    (w_out[gi*CH_W +: CH_W]),
      .o_next_fb (w_fb_nxt[gi*CH_W +: CH_W])
    );
  end

  // --------------------------------------------------------------------------
  // Key latch, feedback chain and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key     <= '0;
      r_mode    <= MODE_ENC;
      r_fb      <= IV;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      if (w_key_hs) begin
        r_key  <= {bus.key1[CH_W-1:0], bus.key2[CH_W-1:0], bus.key3[CH_W-1:0]};
        r_mode <= bus.mode;
        r_fb   <= IV;
      end else if (w_s_hs) begin
        r_fb   <= w_fb_nxt;
      end else if ((r_state == DRAIN) && w_m_hs) begin
        r_fb   <= IV;
      end

      // A load in the same cycle as a drain keeps the register full.
      if (w_s_hs) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_out;
        r_m_last  <= bus.s_last;
      end else if (w_m_hs) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign bus.key_ready = w_key_ready;
  assign bus.s_ready   = w_s_ready;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;
  assign bus.m_last    = r_m_last;
  assign bus.busy      = (r_state != IDLE);

endmodule : pixel_diffuser
`default_nettype wire

// File: tb/tb_pixel_diffuser.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_diffuser
// Description : Self-checking bench for pixel_diffuser. Directed vectors
//               with hand-computed results plus a small channel model for
//               longer frames.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_diffuser;
  import pixel_diffuser_pkg::*;

  localparam logic [23:0] TB_IV = 24'h000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_diffuser_if bus ();

  pixel_diffuser #(.IV(TB_IV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Output monitor: records every output beat and counts stall violations.
  logic [23:0] cap_d[$];
  logic        cap_l[$];
  int          stab_err   = 0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_d     = '0;
  logic        prev_l     = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_d || bus.m_last !== prev_l))
        stab_err++;
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        cap_d.push_back(bus.m_data);
        cap_l.push_back(bus.m_last);
      end
      prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
      prev_d     = bus.m_data;
      prev_l     = bus.m_last;
    end
  end

  // Downstream ready: 0 = held low, 1 = held high, 2 = random.
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required finish earlier)", $time);
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [23:0] src  [64];
  logic [23:0] gold [64];
  logic [23:0] plain[64];

  function automatic logic [7:0] enc8(input logic [7:0] p, input logic [7:0] k, input logic [7:0] f);
    logic [7:0] s;
    s = p + k + f;
    return s ^ k;
  endfunction

  function automatic logic [7:0] dec8(input logic [7:0] p, input logic [7:0] k, input logic [7:0] f);
    logic [7:0] x;
    x = p ^ k;
    return x - k - f;
  endfunction

  task automatic build_gold(input int n, input logic [23:0] key24, input logic md);
    logic [23:0] fb;
    logic [23:0] o;
    fb = TB_IV;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (md) o[c*8 +: 8] = dec8(src[i][c*8 +: 8], key24[c*8 +: 8], fb[c*8 +: 8]);
        else    o[c*8 +: 8] = enc8(src[i][c*8 +: 8], key24[c*8 +: 8], fb[c*8 +: 8]);
      end
      gold[i] = o;
      fb = md ? src[i] : o;
    end
  endtask

  task automatic fill_src(input int n, input logic [31:0] seed_in);
    logic [31:0] seed;
    seed = seed_in;
    for (int i = 0; i < n; i++) begin
      seed = seed * 32'd1664525 + 32'd1013904223;
      src[i] = seed[31:8];
    end
  endtask

  // --------------------------------------------------------------------------
  // Drivers
  // --------------------------------------------------------------------------
  task automatic load_key(input logic [22:0] k1, input logic [22:0] k2, input logic [22:0] k3,
                          input logic md);
    logic ok;
    bus.key1 = k1; bus.key2 = k2; bus.key3 = k3; bus.mode = md;
    bus.key_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.key_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL key_handshake: key_ready=%b after 20 cycles, required 1", bus.key_ready);
    end
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [23:0] d, input logic last, input int gap);
    logic ok;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL pixel_handshake: s_ready=%b after 200 cycles, required 1", bus.s_ready);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic wait_caps(input int target, input string name);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk);
      if (cap_d.size() >= target) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s_timeout: got %0d beats, required %0d", name, cap_d.size(), target);
    end
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    bus.key_valid = 1'b0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.s_data = '0; bus.mode = 1'b0; bus.key1 = '0; bus.key2 = '0; bus.key3 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b, required 0", bus.m_valid); else n_pass++;
    n_total++; if (bus.m_data !== 24'h0) $display("FAIL reset_m_data: got %h, required 000000", bus.m_data); else n_pass++;
    n_total++; if (bus.m_last !== 1'b0) $display("FAIL reset_m_last: got %b, required 0", bus.m_last); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", bus.busy); else n_pass++;
    n_total++; if (bus.key_ready !== 1'b1) $display("FAIL reset_key_ready: got %b, required 1", bus.key_ready); else n_pass++;
    n_total++; if (bus.s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b, required 0", bus.s_ready); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_encrypt();
    int base;
    base = cap_d.size();
    rdy_mode = 1;
    load_key(23'd5, 23'd5, 23'd5, MODE_ENC);
    send_pix(24'h0A0A0A, 1'b0, 0);
    // One cycle after the input handshake the result is presented.
    n_total++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 24'h0A0A0A)
      $display("FAIL basic_latency: got valid=%b data=%h, required valid=1 data=0a0a0a", bus.m_valid, bus.m_data);
    else n_pass++;
    send_pix(24'h0A0A0A, 1'b1, 0);
    wait_caps(base + 2, "basic");
    @(negedge clk);
    n_total++; if (bus.key_ready !== 1'b1) $display("FAIL basic_key_ready_after_last: got %b, required 1", bus.key_ready); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_after_last: got %b, required 0", bus.busy); else n_pass++;
    if (cap_d.size() >= base + 2) begin
      n_total++; if (cap_d[base] !== 24'h0A0A0A) $display("FAIL basic_pix0: got %h, required 0a0a0a", cap_d[base]); else n_pass++;
      n_total++; if (cap_d[base+1] !== 24'h1C1C1C) $display("FAIL basic_pix1: got %h, required 1c1c1c", cap_d[base+1]); else n_pass++;
      n_total++; if (cap_l[base] !== 1'b0 || cap_l[base+1] !== 1'b1)
        $display("FAIL basic_last: got %b%b, required 01", cap_l[base], cap_l[base+1]); else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_key_wrap();
    int base;
    base = cap_d.size();
    load_key(23'd999, 23'd261, 23'd100, MODE_ENC);
    send_pix(24'h000AC8, 1'b1, 0);
    wait_caps(base + 1, "keywrap");
    if (cap_d.size() >= base + 1) begin
      n_total++; if (cap_d[base] !== 24'h000A48) $display("FAIL keywrap_pix: got %h, required 000a48", cap_d[base]); else n_pass++;
      n_total++; if (cap_l[base] !== 1'b1) $display("FAIL keywrap_last: got %b, required 1", cap_l[base]); else n_pass++;
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_round_trip();
    int base;
    int errs;
    logic [23:0] bad_got, bad_exp;
    fill_src(64, 32'h1234_5678);
    for (int i = 0; i < 64; i++) plain[i] = src[i];
    build_gold(64, 24'hDE45A7, MODE_ENC);
    base = cap_d.size();
    load_key(23'h7ABCDE, 23'h012345, 23'h5A5AA7, MODE_ENC);
    for (int i = 0; i < 64; i++) send_pix(src[i], i == 63, 0);
    wait_caps(base + 64, "rt_enc");
    errs = 0; bad_got = '0; bad_exp = '0;
    for (int i = 0; i < 64; i++) begin
      if (base + i >= cap_d.size()) begin errs++; continue; end
      if (cap_d[base+i] !== gold[i]) begin
        if (errs == 0) begin bad_got = cap_d[base+i]; bad_exp = gold[i]; end
        errs++;
      end
    end
    n_total++; if (errs != 0) $display("FAIL rt_encrypt: %0d bad beats, first got %h, required %h", errs, bad_got, bad_exp); else n_pass++;
    repeat (2) @(posedge clk); #1;

    // Decrypt the captured ciphertext; mode is changed right after the key
    // handshake to confirm the latched mode is what counts.
    for (int i = 0; i < 64; i++) src[i] = (base + i < cap_d.size()) ? cap_d[base+i] : 24'h0;
    base = cap_d.size();
    load_key(23'h7ABCDE, 23'h012345, 23'h5A5AA7, MODE_DEC);
    bus.mode = MODE_ENC;
    for (int i = 0; i < 64; i++) send_pix(src[i], i == 63, 0);
    wait_caps(base + 64, "rt_dec");
    errs = 0; bad_got = '0; bad_exp = '0;
    for (int i = 0; i < 64; i++) begin
      if (base + i >= cap_d.size()) begin errs++; continue; end
      if (cap_d[base+i] !== plain[i]) begin
        if (errs == 0) begin bad_got = cap_d[base+i]; bad_exp = plain[i]; end
        errs++;
      end
    end
    n_total++; if (errs != 0) $display("FAIL rt_decrypt: %0d bad beats, first got %h, required %h", errs, bad_got, bad_exp); else n_pass++;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int base;
    int errs;
    int lerrs;
    int stab0;
    logic [23:0] bad_got, bad_exp;
    fill_src(32, 32'hCAFE_0001);
    build_gold(32, 24'h112233, MODE_ENC);
    base  = cap_d.size();
    stab0 = stab_err;
    load_key(23'h000011, 23'h000022, 23'h000033, MODE_ENC);
    rdy_mode = 2;
    for (int i = 0; i < 32; i++) send_pix(src[i], i == 31, $urandom_range(0, 2));
    wait_caps(base + 32, "bp");
    rdy_mode = 1;
    repeat (5) @(posedge clk); #1;
    n_total++; if (cap_d.size() - base != 32) $display("FAIL bp_beat_count: got %0d, required 32", cap_d.size() - base); else n_pass++;
    errs = 0; lerrs = 0; bad_got = '0; bad_exp = '0;
    for (int i = 0; i < 32; i++) begin
      if (base + i >= cap_d.size()) begin errs++; continue; end
      if (cap_d[base+i] !== gold[i]) begin
        if (errs == 0) begin bad_got = cap_d[base+i]; bad_exp = gold[i]; end
        errs++;
      end
      if (cap_l[base+i] !== (i == 31)) lerrs++;
    end
    n_total++; if (errs != 0) $display("FAIL bp_data: %0d bad beats, first got %h, required %h", errs, bad_got, bad_exp); else n_pass++;
    n_total++; if (lerrs != 0) $display("FAIL bp_last: %0d misplaced last flags, required 0", lerrs); else n_pass++;
    n_total++; if (stab_err != stab0) $display("FAIL bp_stable: %0d stall violations, required 0", stab_err - stab0); else n_pass++;
  endtask

  task automatic test_frame_boundary();
    int base;
    int errs;
    src[0] = 24'h102030; src[1] = 24'hFFEE01; src[2] = 24'h7F80C3; src[3] = 24'h000000;
    build_gold(4, 24'h405060, MODE_ENC);
    base = cap_d.size();
    load_key(23'h000040, 23'h000050, 23'h000060, MODE_ENC);
    send_pix(src[0], 1'b0, 0);
    // A competing key set during the frame must be refused.
    bus.key1 = 23'h0000AA; bus.key2 = 23'h0000BB; bus.key3 = 23'h0000CC; bus.mode = MODE_DEC;
    bus.key_valid = 1'b1;
    @(negedge clk);
    n_total++; if (bus.key_ready !== 1'b0) $display("FAIL fb_key_ready_in_run: got %b, required 0", bus.key_ready); else n_pass++;
    @(posedge clk); #1;
    send_pix(src[1], 1'b0, 0);
    send_pix(src[2], 1'b0, 0);
    bus.key_valid = 1'b0;
    send_pix(src[3], 1'b1, 0);
    wait_caps(base + 4, "fb");
    if (cap_d.size() >= base + 4) begin
      n_total++; if (cap_d[base] !== 24'h1020F0) $display("FAIL fb_first_pix: got %h, required 1020f0", cap_d[base]); else n_pass++;
      errs = 0;
      for (int i = 0; i < 4; i++) if (cap_d[base+i] !== gold[i]) errs++;
      n_total++; if (errs != 0) $display("FAIL fb_frame: %0d bad beats, required 0", errs); else n_pass++;
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int base;
    int errs;
    fill_src(8, 32'h0BAD_F00D);
    build_gold(8, 24'h03070B, MODE_ENC);
    load_key(23'd3, 23'd7, 23'd11, MODE_ENC);
    for (int i = 0; i < 3; i++) send_pix(src[i], 1'b0, 0);
    rst = 1'b1;
    #1;
    n_total++; if (bus.m_valid !== 1'b0) $display("FAIL rstmid_m_valid: got %b, required 0", bus.m_valid); else n_pass++;
    n_total++; if (bus.m_data !== 24'h0) $display("FAIL rstmid_m_data: got %h, required 000000", bus.m_data); else n_pass++;
    n_total++; if (bus.busy !== 1'b0 || bus.key_ready !== 1'b1 || bus.s_ready !== 1'b0 || bus.m_last !== 1'b0)
      $display("FAIL rstmid_ctrl: got busy=%b key_ready=%b s_ready=%b m_last=%b, required 0 1 0 0",
               bus.busy, bus.key_ready, bus.s_ready, bus.m_last);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    base = cap_d.size();
    load_key(23'd3, 23'd7, 23'd11, MODE_ENC);
    for (int i = 0; i < 8; i++) send_pix(src[i], i == 7, 0);
    wait_caps(base + 8, "rstmid");
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      if (base + i >= cap_d.size()) errs++;
      else if (cap_d[base+i] !== gold[i]) errs++;
    end
    n_total++; if (errs != 0) $display("FAIL rstmid_new_frame: %0d bad beats, required 0", errs); else n_pass++;
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.key_valid = 1'b0; bus.s_last = 1'b0;
    test_reset();
    test_basic_encrypt();
    test_key_wrap();
    test_round_trip();
    test_backpressure();
    test_frame_boundary();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pixel_diffuser
`default_nettype wire

// File: doc/pixel_diffuser.md
Name: pixel_diffuser

Overview:
Consumes the three 23-bit chaotic key words produced by the key extractor and applies them to an RGB pixel stream. Performs chained (ciphertext-feedback) diffusion per colour channel in encrypt mode and its exact inverse in decrypt mode. One key set is latched per frame. Pixels flow through valid/ready streams at one pixel per cycle with one-cycle registered latency.

Parameters:
IV, 24'h000000, initial feedback value per frame {R[23:16],G[15:8],B[7:0]}
PIX_W, 24, pixel width (3 x 8-bit channels); fixed, not meant to be overridden

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mode  in  1  0 = encrypt, 1 = decrypt; sampled on key handshake
key_valid  in  1  key set available (driven from extractor side)
key_ready  out  1  block accepts key set (high only in IDLE)
key1  in  23  red key word; only bits [7:0] used
key2  in  23  green key word; only bits [7:0] used
key3  in  23  blue key word; only bits [7:0] used
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid & s_ready
s_data  in  24  input pixel {R,G,B}
s_last  in  1  marks last pixel of frame
m_valid  out  1  output pixel valid
m_ready  in  1  downstream ready
m_data  out  24  output pixel {R,G,B}
m_last  out  1  last pixel of frame
busy  out  1  high in RUN and DRAIN

Behaviour:
- Reset: state=IDLE; m_valid=0, m_data=0, m_last=0, busy=0, key_ready=1, s_ready=0; k_r/k_g/k_b=0; feedback=IV; latched mode=0. Reset mid-frame aborts the frame; no partial output survives.
- FSM IDLE -> RUN on key_valid (key_ready=1 in IDLE): latch k_c = key_c[7:0] (i.e. key mod 256), latch mode, feedback <= IV.
- RUN: s_ready = !m_valid | m_ready. On input handshake, compute per channel c (all arithmetic mod 256, 8-bit wrap):
  encrypt: out = ((in + k_c + fb_c) mod 256) XOR k_c; fb_c <= out
  decrypt: out = ((in XOR k_c) - k_c - fb_c) mod 256; fb_c <= in
- Output register loads on the input handshake: m_valid <= 1, m_data <= out, m_last <= s_last. Latency 1 cycle; full throughput when m_ready held high.
- m_valid cleared on m_ready when no new input handshake occurs in the same cycle; simultaneous drain+load keeps m_valid=1 with the new data.
- m_data/m_last held stable while m_valid & !m_ready (no change, no drop).
- Input handshake with s_last=1: RUN -> DRAIN; s_ready=0 in DRAIN.
- DRAIN -> IDLE on m_valid & m_ready (m_last beat); feedback <= IV, key_ready=1 next cycle.
- In IDLE s_ready=0; s_valid ignored. key_valid in RUN/DRAIN ignored (key_ready=0); key inputs may change freely after latch.
- mode changes mid-frame have no effect until next key handshake.
- Single-pixel frame (first pixel has s_last=1) legal: IDLE->RUN->DRAIN->IDLE.

Decomposition:
- Shared package: mode encoding (MODE_ENC=0, MODE_DEC=1), state enum {IDLE,RUN,DRAIN}, CH_W=8, PIX_W=24.
- Sub-module diffuse_channel: combinational 8-bit enc/dec of one channel (in, k, fb, mode -> out, next_fb), instantiated 3x. FSM, handshake and registers live in pixel_diffuser.

Test Plan:
- Basic encrypt: IV=0, key1..3=5, mode=0, pixels {0A0A0A},{0A0A0A}(last) -> m_data 24'h0A0A0A then 24'h1C1C1C, m_last on 2nd beat, key_ready=1 next cycle.
- Key mod/wrap: key1=999 (k=0xE7), key2=261 (k=5), key3=100 (k=0x64), pixel {00,0A,C8} -> {00,0A,48}.
- Round trip: encrypt a 64-pixel random frame, then decrypt the output with same keys/IV and mode=1 -> original pixels bit-exact, including after feedback wrap past 0xFF.
- Backpressure: random m_ready/s_valid toggling over 32-pixel frame -> identical m_data sequence to no-stall run; m_data stable while m_valid & !m_ready; no dropped or duplicated beats.
- Frame boundary: second key set with different keys after m_last -> feedback restarts at IV; first output matches fresh encryption; key_valid asserted during RUN ignored.
- Reset mid-frame: assert rst after 3 of 8 pixels -> all outputs at reset values immediately; new frame after reset matches golden from IV.
